// File: rtl/tf328_pkg.sv
// Shared definitions for the TF328 fast-RAM sequencer: state encoding,
// strobe reset levels and default timing constants.
package tf328_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ROW     = 4'd1,
        ST_COL     = 4'd2,
        ST_DATA    = 4'd3,
        ST_HOLD    = 4'd4,
        ST_PRE     = 4'd5,
        ST_REF_CAS = 4'd6,
        ST_REF_RAS = 4'd7,
        ST_REF_END = 4'd8
    } fm_state_e;

    localparam logic [1:0] RAS_RESET   = 2'b11;
    localparam logic [3:0] CAS_RESET   = 4'b1111;
    localparam logic       ACK_N_RESET = 1'b1;

    localparam int DEFAULT_REFRESH_INTERVAL = 220;
    localparam int DEFAULT_PRECHARGE_CYCLES = 2;

endpackage

// File: rtl/fastmem_refresh_timer.sv
// Free-running refresh interval timer; raises ref_pend on each expiry and
// drops it when the sequencer reports a finished refresh (ref_done).
module fastmem_refresh_timer
    import tf328_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
    input  logic CLKCPU,
    input  logic RESET,
    input  logic ref_done,
    output logic ref_pend
);

    localparam int             CW     = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ref_pend_q, ref_pend_d;

    // Countdown and request flag; a fresh expiry outranks a same-edge clear.
    always_comb begin
        if (cnt_q == '0) begin
            cnt_d      = RELOAD;
            ref_pend_d = 1'b1;
        end else begin
            cnt_d      = cnt_q - CW'(1);
            ref_pend_d = ref_pend_q & ~ref_done;
        end
    end

    // Timer state registers.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= RELOAD;
            ref_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    assign ref_pend = ref_pend_q;

endmodule

// File: rtl/fastmem_sequencer.sv
// TF328 fast-RAM DRAM sequencer: CPU access vs CAS-before-RAS refresh.
// Refresh logic is built only when FASTMEM_REFRESH_EN is defined.
module fastmem_sequencer
    import tf328_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int PRECHARGE_CYCLES = DEFAULT_PRECHARGE_CYCLES
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       RW20,
    input  logic       SEL_n,
    input  logic [1:0] BANK_n,
    input  logic [3:0] LANE_n,
    output logic [1:0] RAS,
    output logic [3:0] CAS,
    output logic       RAM_MUX,
    output logic       ACK_n,
    output logic       REF_BUSY
);

    if (REFRESH_INTERVAL < 16 || PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 7) begin : g_bad_cfg
        $error("fastmem_sequencer: REFRESH_INTERVAL or PRECHARGE_CYCLES out of range");
    end

    localparam logic [2:0] PRE_LOAD = 3'(PRECHARGE_CYCLES - 1);

    fm_state_e  state_q, state_d, idle_next_s;
    logic [2:0] pre_cnt_q, pre_cnt_d;
    logic [1:0] ras_q, ras_d;
    logic [3:0] cas_q, cas_d;
    logic       mux_q, mux_d, ack_q, ack_d, busy_q, busy_d;
    logic       ref_pend_s, cpu_release_s;

`ifdef FASTMEM_REFRESH_EN
    logic ref_done_s;
    assign ref_done_s = (state_q == ST_REF_END);

    fastmem_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .ref_done (ref_done_s),
        .ref_pend (ref_pend_s)
    );
`else
    assign ref_pend_s = 1'b0;
`endif

    // Arbitration taken from IDLE or at the end of precharge; refresh wins.
    always_comb begin
        if (ref_pend_s) begin
            idle_next_s = ST_REF_CAS;
        end else if (!AS20 && !SEL_n) begin
            idle_next_s = ST_ROW;
        end else begin
            idle_next_s = ST_IDLE;
        end
    end

    // Next-state and precharge counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = idle_next_s;
            ST_ROW:     state_d = AS20 ? ST_PRE : ST_COL;
            ST_COL:     state_d = AS20 ? ST_PRE : ST_DATA;
            ST_DATA:    state_d = ST_HOLD;
            ST_HOLD:    state_d = AS20 ? ST_PRE : ST_HOLD;
            ST_PRE:     state_d = (pre_cnt_q == 3'd0) ? idle_next_s : ST_PRE;
`ifdef FASTMEM_REFRESH_EN
            ST_REF_CAS: state_d = ST_REF_RAS;
            ST_REF_RAS: state_d = ST_REF_END;
            ST_REF_END: state_d = ST_PRE;
`endif
            default:    state_d = ST_IDLE;
        endcase

        if (state_d == ST_PRE && state_q != ST_PRE) begin
            pre_cnt_d = PRE_LOAD;
        end else if (state_q == ST_PRE && pre_cnt_q != 3'd0) begin
            pre_cnt_d = pre_cnt_q - 3'd1;
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
    end

    // Outputs follow the current state one edge later, except that a CPU
    // release drops every strobe on the very edge that samples AS20 high.
    assign cpu_release_s = AS20 && (state_q inside {ST_ROW, ST_COL, ST_HOLD});

    // Output decode feeding the output registers.
    always_comb begin
        ras_d  = RAS_RESET;
        cas_d  = CAS_RESET;
        mux_d  = 1'b0;
        ack_d  = ACK_N_RESET;
        busy_d = 1'b0;
        if (cpu_release_s) begin
            ras_d = RAS_RESET;
        end else begin
            case (state_q)
                ST_ROW: ras_d = BANK_n;
                ST_COL: begin
                    ras_d = BANK_n;
                    mux_d = 1'b1;
                end
                ST_DATA, ST_HOLD: begin
                    ras_d = BANK_n;
                    mux_d = 1'b1;
                    cas_d = RW20 ? 4'b0000 : LANE_n;
                    ack_d = 1'b0;
                end
`ifdef FASTMEM_REFRESH_EN
                ST_REF_CAS: begin
                    cas_d  = 4'b0000;
                    busy_d = 1'b1;
                end
                ST_REF_RAS: begin
                    ras_d  = 2'b00;
                    cas_d  = 4'b0000;
                    busy_d = 1'b1;
                end
                ST_REF_END: begin
                    ras_d  = 2'b00;
                    busy_d = 1'b1;
                end
`endif
                default: busy_d = 1'b0;
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            pre_cnt_q <= 3'd0;
            ras_q     <= RAS_RESET;
            cas_q     <= CAS_RESET;
            mux_q     <= 1'b0;
            ack_q     <= ACK_N_RESET;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            ras_q     <= ras_d;
            cas_q     <= cas_d;
            mux_q     <= mux_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign RAS      = ras_q;
    assign CAS      = cas_q;
    assign RAM_MUX  = mux_q;
    assign ACK_n    = ack_q;
    assign REF_BUSY = busy_q;

endmodule

// File: tb/tb_fastmem_sequencer.sv
// Self-checking bench for fastmem_sequencer: directed scenarios plus random
// bus traffic compared cycle by cycle against a behavioural model.
module tb_fastmem_sequencer;

    localparam int RI = 16;
    localparam int PC = 2;
`ifdef FASTMEM_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic       CLKCPU = 1'b0;
    logic       RESET;
    logic       as20, rw20, sel_n;
    logic [1:0] bank_n;
    logic [3:0] lane_n;
    logic [1:0] RAS;
    logic [3:0] CAS;
    logic       RAM_MUX, ACK_n, REF_BUSY;

    int n_checks = 0;
    int n_errors = 0;

    // Model: activity kind (0 idle, 1 CPU access, 2 refresh, 3 precharge),
    // edges spent in it, precharge cycles left, refresh timer and request.
    int         m_kind, m_age, m_pre, m_tmr;
    bit         m_pend;
    logic [1:0] e_ras;
    logic [3:0] e_cas;
    logic       e_mux, e_ack, e_busy;

    fastmem_sequencer #(
        .REFRESH_INTERVAL (RI),
        .PRECHARGE_CYCLES (PC)
    ) dut (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .AS20     (as20),
        .RW20     (rw20),
        .SEL_n    (sel_n),
        .BANK_n   (bank_n),
        .LANE_n   (lane_n),
        .RAS      (RAS),
        .CAS      (CAS),
        .RAM_MUX  (RAM_MUX),
        .ACK_n    (ACK_n),
        .REF_BUSY (REF_BUSY)
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind = 0; m_age = 0; m_pre = 0; m_tmr = RI - 1; m_pend = 1'b0;
        e_ras = 2'b11; e_cas = 4'hF; e_mux = 1'b0; e_ack = 1'b1; e_busy = 1'b0;
    endtask

    task automatic model_accept();
        if (m_pend) begin
            m_kind = 2; m_age = 1;
        end else if (!as20 && !sel_n) begin
            m_kind = 1; m_age = 1;
        end else begin
            m_kind = 0;
        end
    endtask

    // One rising edge of the reference: expected outputs right after it.
    task automatic model_edge();
        bit expire, clr;
        expire = REF_EN && (m_tmr == 0);
        clr    = 1'b0;
        e_ras = 2'b11; e_cas = 4'hF; e_mux = 1'b0; e_ack = 1'b1; e_busy = 1'b0;
        case (m_kind)
            0: model_accept();
            1: begin
                if (as20 && m_age != 3) begin
                    m_kind = 3; m_pre = PC;
                end else begin
                    e_ras = bank_n;
                    if (m_age >= 2) e_mux = 1'b1;
                    if (m_age >= 3) begin
                        e_cas = rw20 ? 4'b0000 : lane_n;
                        e_ack = 1'b0;
                    end
                    m_age++;
                end
            end
            2: begin
                e_busy = 1'b1;
                if (m_age <= 2) e_cas = 4'b0000;
                if (m_age >= 2) e_ras = 2'b00;
                if (m_age == 3) begin
                    clr = 1'b1; m_kind = 3; m_pre = PC;
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (m_pre > 1) m_pre--;
                else model_accept();
            end
        endcase
        m_pend = expire ? 1'b1 : (clr ? 1'b0 : m_pend);
        if (REF_EN) m_tmr = expire ? RI - 1 : m_tmr - 1;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_ras"},  {6'd0, RAS},      {6'd0, e_ras});
        check_val({tag, "_cas"},  {4'd0, CAS},      {4'd0, e_cas});
        check_val({tag, "_mux"},  {7'd0, RAM_MUX},  {7'd0, e_mux});
        check_val({tag, "_ack"},  {7'd0, ACK_n},    {7'd0, e_ack});
        check_val({tag, "_busy"}, {7'd0, REF_BUSY}, {7'd0, e_busy});
    endtask

    // Called at a falling edge: drive, take the rising edge, check, return at the next falling edge.
    task automatic cycle(input bit as, input bit sel, input bit rw, input logic [1:0] bk, input logic [3:0] ln);
        as20 = as; sel_n = sel; rw20 = rw; bank_n = bk; lane_n = ln;
        @(posedge CLKCPU);
        model_edge();
        #1;
        check_outputs("cyc");
        @(negedge CLKCPU);
    endtask

    initial begin
        int         lat, gap, hold;
        bit         rw, sel;
        logic [1:0] bk;
        logic [3:0] ln;

        RESET = 1'b0; as20 = 1'b1; rw20 = 1'b1; sel_n = 1'b1; bank_n = 2'b11; lane_n = 4'hF;
        model_reset();
        repeat (2) @(negedge CLKCPU);
        check_outputs("rst");
        RESET = 1'b1;

        // Read, bank 0
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        check_val("rd_ras", {6'd0, RAS}, 8'h02);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        check_val("rd_mux", {7'd0, RAM_MUX}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        check_val("rd_cas", {4'd0, CAS}, 8'h00);
        check_val("rd_ack", {7'd0, ACK_n}, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);
        check_val("rd_rel_ras", {6'd0, RAS}, 8'h03);
        check_val("rd_rel_cas", {4'd0, CAS}, 8'h0F);
        check_val("rd_rel_ack", {7'd0, ACK_n}, 8'h01);
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);

        // Write, bank 1, upper word
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011);
        check_val("wr_cas", {4'd0, CAS}, 8'h03);
        check_val("wr_ras", {6'd0, RAS}, 8'h01);
        check_val("wr_ack", {7'd0, ACK_n}, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);
        repeat (16) cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);

        // Abort while in COL
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        check_val("ab_row", {6'd0, RAS}, 8'h02);
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);
        check_val("ab_ras", {6'd0, RAS}, 8'h03);
        check_val("ab_ack", {7'd0, ACK_n}, 8'h01);
        repeat (10) cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);

        // Reset while in HOLD
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 2'b01, 4'hF);
        #2;
        RESET = 1'b0;
        as20 = 1'b1; sel_n = 1'b1;
        #1;
        model_reset();
        check_outputs("hold_rst");
        @(negedge CLKCPU);
        RESET = 1'b1;

        // Collision: access arrives on the edge the first refresh is taken
        repeat (RI) cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 2'b10, 4'hF);
            if (lat < 0 && ACK_n == 1'b0) lat = k;
        end
        check_val("coll_lat", lat[7:0], REF_EN ? 8'(3 + PC + 3) : 8'd3);
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);

        // Random traffic
        for (int t = 0; t < 250; t++) begin
            gap  = $urandom_range(0, 6);
            hold = $urandom_range(1, 12);
            rw   = 1'($urandom_range(0, 1));
            sel  = ($urandom_range(0, 7) == 0);
            bk   = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            ln   = 4'($urandom_range(0, 15));
            for (int g = 0; g < gap; g++) cycle(1'b1, 1'($urandom_range(0, 1)), rw, bk, ln);
            for (int h = 0; h < hold; h++) cycle(1'b0, sel, rw, bk, ln);
        end
        repeat (8) cycle(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
